// File: rtl/klingon_pkg.sv
// klingon_pkg: shared types, glyph constants and the code-to-glyph lookup
// for the Klingon numeral seven-segment decoder.
// Segment order is {a,b,c,d,e,f,g} on bits 6..0, 1 = lit.
package klingon_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t GLYPH_0     = 7'b1000001;
  localparam seg_t GLYPH_1     = 7'b0000001;
  localparam seg_t GLYPH_2     = 7'b0001001;
  localparam seg_t GLYPH_3     = 7'b1001001;
  localparam seg_t GLYPH_4     = 7'b0110000;
  localparam seg_t GLYPH_5     = 7'b0110001;
  localparam seg_t GLYPH_6     = 7'b0111001;
  localparam seg_t GLYPH_7     = 7'b1111001;
  localparam seg_t GLYPH_8     = 7'b0000110;
  localparam seg_t GLYPH_9     = 7'b0000111;
  localparam seg_t GLYPH_ERR   = 7'b0110111;
  localparam seg_t GLYPH_BLANK = 7'b0000000;

  // Codes 10-15 are not Klingon digits and all share the error glyph.
  function automatic seg_t glyph_lookup(input logic [3:0] code);
    seg_t g;
    case (code)
      4'd0:    g = GLYPH_0;
      4'd1:    g = GLYPH_1;
      4'd2:    g = GLYPH_2;
      4'd3:    g = GLYPH_3;
      4'd4:    g = GLYPH_4;
      4'd5:    g = GLYPH_5;
      4'd6:    g = GLYPH_6;
      4'd7:    g = GLYPH_7;
      4'd8:    g = GLYPH_8;
      4'd9:    g = GLYPH_9;
      default: g = GLYPH_ERR;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/klingon_glyph_rom.sv
// klingon_glyph_rom: purely combinational 4-bit code to active-high glyph
// lookup; holds no state so it cannot remember anything between codes.
import klingon_pkg::*;

module klingon_glyph_rom (
  input  logic [3:0] in,
  output seg_t       seg
);

  // Straight table lookup through the shared package function.
  always_comb begin
    seg = glyph_lookup(in);
  end

endmodule

// File: rtl/klingon.sv
// klingon: registered Klingon numeral seven-segment decoder, one clock of
// latency from in to out, blank on asynchronous active-low reset.
// Build option KLINGON_ACTIVE_LOW_EN: invert every segment for
// common-anode displays (the blank reset value becomes all ones).
import klingon_pkg::*;

module klingon (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] in,
  output logic [6:0] out
);

`ifdef KLINGON_ACTIVE_LOW_EN
  localparam seg_t SEG_INVERT = 7'b1111111;
`else
  localparam seg_t SEG_INVERT = 7'b0000000;
`endif

  localparam seg_t RESET_VALUE = GLYPH_BLANK ^ SEG_INVERT;

  seg_t glyph;
  seg_t seg_next;

  klingon_glyph_rom u_rom (
    .in  (in),
    .seg (glyph)
  );

  // Apply the display polarity after lookup so the register holds pin levels.
  always_comb begin
    seg_next = glyph ^ SEG_INVERT;
  end

  // Single output register; reset blanks the digit without needing a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= RESET_VALUE;
    end else begin
      out <= seg_next;
    end
  end

endmodule

// File: tb/tb_klingon.sv
// tb_klingon: directed-vector scoreboard bench for the klingon decoder.
// Expected glyphs are hand-entered; a monitor drains the expectation queue
// whenever the stimulus signals that out should be sampled.
`timescale 1ns/1ps

module tb_klingon;

  typedef struct {
    logic [6:0] expVal;
    string      tag;
  } expect_t;

`ifdef KLINGON_ACTIVE_LOW_EN
  localparam logic [6:0] POL = 7'b1111111;
`else
  localparam logic [6:0] POL = 7'b0000000;
`endif

  logic       clk;
  logic       rst_n;
  logic [3:0] in;
  logic [6:0] out;

  logic       clkRun;
  logic [6:0] glyphTab [0:15];
  expect_t    sbq [$];
  event       sampleEv;
  int         checks;
  int         errors;

  klingon dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (in),
    .out   (out)
  );

  // Free-running clock that can be held low for the clockless reset check.
  always begin
    #5;
    if (clkRun) clk = ~clk;
  end

  // Monitor: compares out against every queued expectation when told to sample.
  initial begin
    expect_t e;
    forever begin
      @(sampleEv);
      while (sbq.size() > 0) begin
        e = sbq.pop_front();
        checks++;
        if (out !== e.expVal) begin
          errors++;
          $display("[TB] FAIL %s: out=%b expected=%b", e.tag, out, e.expVal);
        end
      end
    end
  end

  task automatic checkOutput(input logic [6:0] expVal, input string tag);
    expect_t e;
    e.expVal = expVal;
    e.tag    = tag;
    sbq.push_back(e);
    ->sampleEv;
    #0;
  endtask

  // Drive a code away from the edge, then expect its glyph just after the edge.
  task automatic applyStimulus(input logic [3:0] code);
    @(negedge clk);
    in = code;
    @(posedge clk);
    #1;
    checkOutput(glyphTab[code] ^ POL, $sformatf("code%0d", code));
  endtask

  initial begin
    glyphTab[0]  = 7'b1000001;
    glyphTab[1]  = 7'b0000001;
    glyphTab[2]  = 7'b0001001;
    glyphTab[3]  = 7'b1001001;
    glyphTab[4]  = 7'b0110000;
    glyphTab[5]  = 7'b0110001;
    glyphTab[6]  = 7'b0111001;
    glyphTab[7]  = 7'b1111001;
    glyphTab[8]  = 7'b0000110;
    glyphTab[9]  = 7'b0000111;
    for (int i = 10; i < 16; i++) glyphTab[i] = 7'b0110111;

    checks = 0;
    errors = 0;
    clk    = 1'b0;
    clkRun = 1'b0;
    rst_n  = 1'b1;
    in     = 4'd7;

    // Reset with the clock stopped must blank out immediately.
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput(7'b0000000 ^ POL, "resetNoClock");

    // Reset held across three edges keeps out blank.
    clkRun = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput(7'b0000000 ^ POL, $sformatf("resetHold%0d", i));
    end

    // Release between edges, then sweep the digit codes.
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) applyStimulus(4'(i));

    // Error range 10-15.
    for (int i = 10; i < 16; i++) applyStimulus(4'(i));

    // Latency/hold: a mid-cycle change must not reach out before the edge.
    applyStimulus(4'd4);
    #2;
    in = 4'd8;
    #1;
    checkOutput(glyphTab[4] ^ POL, "holdBeforeEdge");
    @(posedge clk);
    #1;
    checkOutput(glyphTab[8] ^ POL, "afterEdge8");

    // Mid-stream reset pulse between edges.
    applyStimulus(4'd7);
    #1;
    in    = 4'd2;
    rst_n = 1'b0;
    #1;
    checkOutput(7'b0000000 ^ POL, "midReset");
    #1;
    rst_n = 1'b1;
    #1;
    checkOutput(7'b0000000 ^ POL, "blankAfterRelease");
    @(posedge clk);
    #1;
    checkOutput(glyphTab[2] ^ POL, "firstEdgeAfterRelease");

    #2;
    if (sbq.size() != 0) begin
      errors += sbq.size();
      $display("[TB] FAIL scoreboard: pending=%0d required=0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
